// File: rtl/l1_mem_arb.sv
// l1_mem_arb: arbitrates L1D/L1I miss and writeback requests onto a single
// downstream memory port with exactly one transaction outstanding.
// Ties between requesters are broken round-robin on the last winner.
module l1_mem_arb #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   // L1D requester
   input  logic              l1d_req_valid,
   input  logic [ADDR_W-1:0] l1d_req_addr,
   input  logic [3:0]        l1d_req_opcode,
   input  logic [DATA_W-1:0] l1d_req_store_data,
   output logic              l1d_req_ack,
   output logic              l1d_rsp_valid,
   // L1I requester
   input  logic              l1i_req_valid,
   input  logic [ADDR_W-1:0] l1i_req_addr,
   input  logic [3:0]        l1i_req_opcode,
   output logic              l1i_req_ack,
   output logic              l1i_rsp_valid,
   // shared response data
   output logic [DATA_W-1:0] rsp_load_data,
   // downstream memory port
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [3:0]        mem_req_opcode,
   output logic [DATA_W-1:0] mem_req_store_data,
   output logic              mem_req_src,
   input  logic              mem_req_ack,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_load_data,
   // flush / status
   input  logic              flush_hold,
   output logic              drained,
   output logic              rsp_err,
   output logic [31:0]       l1d_grants,
   output logic [31:0]       l1i_grants
);

   localparam int unsigned OP_W  = 4;
   localparam int unsigned CNT_W = 32;
   localparam logic        SRC_D = 1'b0;
   localparam logic        SRC_I = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ISSUE    = 2'd1,
      S_WAIT_RSP = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_last;
   logic               r_mem_req_valid;
   logic [ADDR_W-1:0]  r_addr;
   logic [OP_W-1:0]    r_opcode;
   logic [DATA_W-1:0]  r_store_data;
   logic               r_src;
   logic               r_rsp_err;
   logic [CNT_W-1:0]   r_l1d_grants;
   logic [CNT_W-1:0]   r_l1i_grants;

   logic               w_idle;
   logic               w_arb_ok;
   logic               w_grant_d;
   logic               w_grant_i;
   logic               w_rsp_hit;

   // Grant decision: only in IDLE, not while flushing; tie goes to non-last winner
   assign w_idle    = (r_state == S_IDLE);
   assign w_arb_ok  = w_idle & ~flush_hold & ~reset;
   assign w_grant_d = w_arb_ok & l1d_req_valid & (~l1i_req_valid | (r_last == SRC_I));
   assign w_grant_i = w_arb_ok & l1i_req_valid & (~l1d_req_valid | (r_last == SRC_D));
   assign w_rsp_hit = (r_state == S_WAIT_RSP) & mem_rsp_valid & ~reset;

   // Combinational handshakes and status
   assign l1d_req_ack   = w_grant_d;
   assign l1i_req_ack   = w_grant_i;
   assign l1d_rsp_valid = w_rsp_hit & (r_src == SRC_D);
   assign l1i_rsp_valid = w_rsp_hit & (r_src == SRC_I);
   assign rsp_load_data = mem_rsp_load_data;
   assign drained       = flush_hold & (w_idle | reset);

   // Registered outputs
   assign mem_req_valid      = r_mem_req_valid;
   assign mem_req_addr       = r_addr;
   assign mem_req_opcode     = r_opcode;
   assign mem_req_store_data = r_store_data;
   assign mem_req_src        = r_src;
   assign rsp_err            = r_rsp_err;
   assign l1d_grants         = r_l1d_grants;
   assign l1i_grants         = r_l1i_grants;

   // Transaction FSM, request latch, counters and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_last          <= SRC_I;
         r_mem_req_valid <= 1'b0;
         r_addr          <= '0;
         r_opcode        <= '0;
         r_store_data    <= '0;
         r_src           <= SRC_D;
         r_rsp_err       <= 1'b0;
         r_l1d_grants    <= '0;
         r_l1i_grants    <= '0;
      end else begin
         if (mem_rsp_valid && (r_state != S_WAIT_RSP))
            r_rsp_err <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_grant_d) begin
                  r_state         <= S_ISSUE;
                  r_mem_req_valid <= 1'b1;
                  r_addr          <= l1d_req_addr;
                  r_opcode        <= l1d_req_opcode;
                  r_store_data    <= l1d_req_store_data;
                  r_src           <= SRC_D;
                  r_last          <= SRC_D;
                  r_l1d_grants    <= r_l1d_grants + CNT_W'(1);
               end else if (w_grant_i) begin
                  r_state         <= S_ISSUE;
                  r_mem_req_valid <= 1'b1;
                  r_addr          <= l1i_req_addr;
                  r_opcode        <= l1i_req_opcode;
                  r_store_data    <= '0;
                  r_src           <= SRC_I;
                  r_last          <= SRC_I;
                  r_l1i_grants    <= r_l1i_grants + CNT_W'(1);
               end
            end
            S_ISSUE: begin
               if (mem_req_ack) begin
                  r_state         <= S_WAIT_RSP;
                  r_mem_req_valid <= 1'b0;
               end
            end
            S_WAIT_RSP: begin
               if (mem_rsp_valid)
                  r_state <= S_IDLE;
            end
            default: begin
               r_state         <= S_IDLE;
               r_mem_req_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/l1_mem_arb.md
L1_MEM_ARB -- requirements
Module: l1_mem_arb

Interface
REQ-001 Parameter ADDR_W, 32, request address width.
REQ-002 Parameter DATA_W, 128, store/load line width.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 l1d_req_valid / l1i_req_valid  input  1  requester has a miss/writeback pending; held until its ack.
REQ-006 l1d_req_addr / l1i_req_addr  input  ADDR_W  request address.
REQ-007 l1d_req_opcode / l1i_req_opcode  input  4  memory opcode.
REQ-008 l1d_req_store_data  input  DATA_W  writeback data (L1I has none; forwarded as zero).
REQ-009 l1d_req_ack / l1i_req_ack  output  1  one-cycle grant pulse.
REQ-010 l1d_rsp_valid / l1i_rsp_valid  output  1  response for that requester.
REQ-011 rsp_load_data  output  DATA_W  mem_rsp_load_data, passed through unregistered.
REQ-012 mem_req_valid  output  1  downstream request valid.
REQ-013 mem_req_addr / mem_req_opcode / mem_req_store_data / mem_req_src  output  ADDR_W/4/DATA_W/1  latched request fields; src 0=L1D, 1=L1I.
REQ-014 mem_req_ack  input  1  downstream accepted request.
REQ-015 mem_rsp_valid / mem_rsp_load_data  input  1/DATA_W  downstream response.
REQ-016 flush_hold  input  1  level; blocks new grants.
REQ-017 drained  output  1  flush_hold high and arbiter idle.
REQ-018 rsp_err  output  1  sticky: unexpected response seen.
REQ-019 l1d_grants / l1i_grants  output  32  grant counters.

Function
REQ-020 States IDLE, ISSUE, WAIT_RSP; exactly one transaction outstanding.
REQ-021 IDLE, flush_hold=0, any valid: select winner, pulse its req_ack combinationally that cycle, latch addr/opcode/store_data/src, go ISSUE.
REQ-022 Both valid in IDLE: grant requester other than r_last; r_last updated to winner on every grant.
REQ-023 Single valid: granted regardless of r_last.
REQ-024 ISSUE: mem_req_valid=1, fields stable; on mem_req_ack go WAIT_RSP (mem_req_valid low next cycle).
REQ-025 WAIT_RSP: on mem_rsp_valid assert rsp_valid of latched src in the same cycle (combinational), go IDLE.
REQ-026 Minimum grant-to-response: 2 cycles (ack in ISSUE cycle, rsp next cycle); next grant earliest the cycle after response.
REQ-027 Requester ignored in cycles other than IDLE grant; valid held high during ISSUE/WAIT_RSP is not re-granted.
REQ-028 mem_rsp_valid in IDLE or ISSUE: ignored, no rsp_valid, rsp_err set until reset.
REQ-029 flush_hold affects IDLE only; in-flight transaction completes normally.
REQ-030 drained = flush_hold & (state==IDLE), combinational.
REQ-031 Grant counters increment by 1 per grant, wrap 0xFFFFFFFF->0.
REQ-032 l1i grant drives mem_req_store_data = 0.

Reset
REQ-033 Reset: state IDLE, r_last=L1I (L1D wins first tie), rsp_err=0, counters=0, latched fields=0.
REQ-034 Reset outputs: mem_req_valid=0, all req_ack=0, all rsp_valid=0, drained=flush_hold.
REQ-035 Reset mid-transaction drops it; later mem_rsp_valid sets rsp_err.

Verification
REQ-036 Both valid at cycle 0 after reset -> l1d_req_ack cycle 0, mem_req_src=0; after response, l1i granted next IDLE cycle, mem_req_src=1.
REQ-037 L1D addr 0x1000 opcode 4 data 0xA5..A5; mem_req_ack delayed 3 cycles -> mem_req_valid held 4 cycles with fields stable; rsp -> l1d_rsp_valid only, l1d_grants=1.
REQ-038 Continuous both-valid for 6 transactions -> grant order D,I,D,I,D,I; counters 3/3.
REQ-039 flush_hold raised during WAIT_RSP with l1i valid -> response delivered, no grant, drained=1 from next cycle; drop flush_hold -> l1i granted that cycle.
REQ-040 mem_rsp_valid pulsed while IDLE -> no rsp_valid, rsp_err=1 until reset.
REQ-041 Reset asserted in ISSUE -> mem_req_valid=0 next cycle, state IDLE, counters 0.
